// File: rtl/ecc_dec_module_if.sv
// ---------------------------------------------------------------------------
// ecc_dec_module_if
//   Handshake and data bundle of the ECC decoder read path.
//   Input side  : i_vld, i_rdy, i_code[37:0]  ({check[5:0], data[31:0]})
//   Output side : o_vld, o_rdy, o_data[31:0], o_cor, o_unc, o_syn[5:0]
//   Modports    : slave  - the decoder (consumes i_*, produces o_*)
//                 master - the environment (produces i_*, consumes o_*)
// ---------------------------------------------------------------------------
interface ecc_dec_module_if;
  logic        i_vld;
  logic        i_rdy;
  logic [37:0] i_code;
  logic        o_vld;
  logic        o_rdy;
  logic [31:0] o_data;
  logic        o_cor;
  logic        o_unc;
  logic [5:0]  o_syn;

  modport slave (
    input  i_vld, i_code, o_rdy,
    output i_rdy, o_vld, o_data, o_cor, o_unc, o_syn
  );

  modport master (
    output i_vld, i_code, o_rdy,
    input  i_rdy, o_vld, o_data, o_cor, o_unc, o_syn
  );
endinterface

// File: rtl/ecc_dec_module.sv
// ---------------------------------------------------------------------------
// ecc_dec_module
//   Decoder for the 38-bit words produced by ecc_enc_module.
//   Recomputes the check bits, forms a 6-bit syndrome, corrects any single
//   data- or check-bit error and flags everything else as uncorrectable.
//   Two-stage valid/ready pipeline (S1: code + syndrome, S2: result), with
//   saturating correction/uncorrectable counters and a capture register for
//   the first uncorrectable word since reset or cnt_clr.
//
// Ports
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   bus       if   ecc_dec_module_if.slave (i_vld/i_rdy/i_code,
//                  o_vld/o_rdy/o_data/o_cor/o_unc/o_syn)
//   cnt_clr   in   synchronous clear of counters and capture register
//   cor_cnt   out  delivered-correction count (saturating, CNT_W bits)
//   unc_cnt   out  delivered-uncorrectable count (saturating, CNT_W bits)
//   cap_vld   out  capture register holds an uncorrectable word
//   cap_code  out  raw code of the first uncorrectable word
// ---------------------------------------------------------------------------
module ecc_dec_module #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  ecc_dec_module_if.slave  bus,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] cor_cnt,
  output logic [CNT_W-1:0] unc_cnt,
  output logic             cap_vld,
  output logic [37:0]      cap_code
);

  // -------------------------------------------------------------------------
  // Encoder equations. Each data bit j toggles the check bits set in
  // ENC_COL[j]; the constant term inverts code bits 36, 34 and 32
  // (check bits 4, 2, 0). Every column has weight >= 2 and all are distinct,
  // so no single data-bit error can look like a check-bit error. 6'b111000
  // is deliberately unused.
  // -------------------------------------------------------------------------
  localparam logic [5:0] CHK_CONST = 6'b010101;

  localparam logic [5:0] ENC_COL [32] = '{
    6'd11, 6'd13, 6'd14, 6'd19, 6'd21, 6'd22, 6'd25, 6'd26,
    6'd28, 6'd35, 6'd37, 6'd38, 6'd41, 6'd42, 6'd44, 6'd49,
    6'd50, 6'd52, 6'd7,  6'd15, 6'd23, 6'd27, 6'd29, 6'd30,
    6'd39, 6'd31, 6'd47, 6'd55, 6'd59, 6'd61, 6'd62, 6'd63
  };

  function automatic logic [5:0] chk(input logic [31:0] d);
    logic [5:0] c;
    c = CHK_CONST;
    for (int j = 0; j < 32; j++) begin
      if (d[j]) c = c ^ ENC_COL[j];
    end
    return c;
  endfunction

  // -------------------------------------------------------------------------
  // Pipeline state
  // -------------------------------------------------------------------------
  logic        s1_vld;
  logic [37:0] s1_code;
  logic [5:0]  s1_syn;

  logic        s2_vld;
  logic [31:0] s2_data;
  logic        s2_cor;
  logic        s2_unc;
  logic [5:0]  s2_syn;

  logic s2_adv;
  logic s1_adv;
  logic accept;
  logic deliver;

  assign s2_adv  = ~s2_vld | bus.o_rdy;
  assign s1_adv  = ~s1_vld | s2_adv;
  assign accept  = bus.i_vld & s1_adv;
  assign deliver = s2_vld & bus.o_rdy;

  assign bus.i_rdy  = s1_adv;
  assign bus.o_vld  = s2_vld;
  assign bus.o_data = s2_data;
  assign bus.o_cor  = s2_cor;
  assign bus.o_unc  = s2_unc;
  assign bus.o_syn  = s2_syn;

  // Syndrome of the incoming word, registered into S1
  logic [5:0] in_syn;
  assign in_syn = bus.i_code[37:32] ^ chk(bus.i_code[31:0]);

  // -------------------------------------------------------------------------
  // Column table (single data-bit syndromes) and per-column match against
  // the S1 syndrome. Built from the encoder function so the two can never
  // drift apart.
  // -------------------------------------------------------------------------
  logic [5:0]  col [32];
  logic [31:0] match;

  generate
    for (genvar gi = 0; gi < 32; gi++) begin : g_col
      localparam logic [5:0] COL_VAL = chk(32'd1 << gi) ^ chk(32'd0);
      assign col[gi]   = COL_VAL;
      assign match[gi] = (s1_syn == col[gi]);
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Classification of the S1 word
  // -------------------------------------------------------------------------
  logic [31:0] flip;
  logic        syn_zero;
  logic        syn_onehot;
  logic        cls_cor;
  logic        cls_unc;
  logic [31:0] cls_data;

  always_comb begin
    // Isolate the lowest matching column so aliased columns resolve to lowest j
    flip       = match & (~match + 32'd1);
    syn_zero   = (s1_syn == 6'd0);
    syn_onehot = ~syn_zero & ((s1_syn & (s1_syn - 6'd1)) == 6'd0);
    cls_cor    = syn_onehot | (|match);
    cls_unc    = ~syn_zero & ~cls_cor;
    // Check-bit errors and uncorrectable words pass data through untouched
    cls_data   = s1_code[31:0];
    if (!syn_onehot && !cls_unc) begin
      cls_data = s1_code[31:0] ^ flip;
    end
  end

  // -------------------------------------------------------------------------
  // Stage registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld  <= 1'b0;
      s1_code <= '0;
      s1_syn  <= '0;
    end else if (s1_adv) begin
      s1_vld <= bus.i_vld;
      if (bus.i_vld) begin
        s1_code <= bus.i_code;
        s1_syn  <= in_syn;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_vld  <= 1'b0;
      s2_data <= '0;
      s2_cor  <= 1'b0;
      s2_unc  <= 1'b0;
      s2_syn  <= '0;
    end else if (s2_adv) begin
      s2_vld <= s1_vld;
      if (s1_vld) begin
        s2_data <= cls_data;
        s2_cor  <= cls_cor;
        s2_unc  <= cls_unc;
        s2_syn  <= s1_syn;
      end
    end
  end

  // S2 also keeps the raw code so an uncorrectable delivery can be captured
  logic [37:0] s2_code;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_code <= '0;
    end else if (s2_adv && s1_vld) begin
      s2_code <= s1_code;
    end
  end

  // -------------------------------------------------------------------------
  // Error counters and capture register
  // -------------------------------------------------------------------------
  logic             cor_hit;
  logic             unc_hit;
  logic [CNT_W-1:0] cor_cnt_next;
  logic [CNT_W-1:0] unc_cnt_next;
  logic             cap_vld_next;
  logic [37:0]      cap_code_next;

  assign cor_hit = deliver & s2_cor;
  assign unc_hit = deliver & s2_unc;

  always_comb begin
    cor_cnt_next  = cor_cnt;
    unc_cnt_next  = unc_cnt;
    cap_vld_next  = cap_vld;
    cap_code_next = cap_code;
    if (cnt_clr) begin
      // A clear coincident with a delivery counts/captures that delivery
      cor_cnt_next  = cor_hit ? CNT_W'(1) : '0;
      unc_cnt_next  = unc_hit ? CNT_W'(1) : '0;
      cap_vld_next  = unc_hit;
      cap_code_next = unc_hit ? s2_code : '0;
    end else begin
      if (cor_hit && (cor_cnt != '1)) cor_cnt_next = cor_cnt + CNT_W'(1);
      if (unc_hit && (unc_cnt != '1)) unc_cnt_next = unc_cnt + CNT_W'(1);
      if (unc_hit && !cap_vld) begin
        cap_vld_next  = 1'b1;
        cap_code_next = s2_code;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cor_cnt  <= '0;
      unc_cnt  <= '0;
      cap_vld  <= 1'b0;
      cap_code <= '0;
    end else begin
      cor_cnt  <= cor_cnt_next;
      unc_cnt  <= unc_cnt_next;
      cap_vld  <= cap_vld_next;
      cap_code <= cap_code_next;
    end
  end

endmodule

// File: tb/tb_ecc_dec_module.sv
// ---------------------------------------------------------------------------
// tb_ecc_dec_module
//   Directed and randomized checks of ecc_dec_module (CNT_W = 4) against a
//   transaction-level reference: expected results are held in a FIFO of
//   accepted words, occupancy/age determine o_vld and i_rdy, and counters
//   and the capture register are modelled per delivery.
// ---------------------------------------------------------------------------
module tb_ecc_dec_module;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cnt_clr = 1'b0;
  logic [CNT_W-1:0] cor_cnt;
  logic [CNT_W-1:0] unc_cnt;
  logic             cap_vld;
  logic [37:0]      cap_code;

  ecc_dec_module_if bus ();

  ecc_dec_module #(.CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .cnt_clr  (cnt_clr),
    .cor_cnt  (cor_cnt),
    .unc_cnt  (unc_cnt),
    .cap_vld  (cap_vld),
    .cap_code (cap_code)
  );

  always #5 clk = ~clk;

  // Single data-bit syndromes of the encoder, j = 0..31
  int unsigned cols [32] = '{
    'b001011, 'b001101, 'b001110, 'b010011, 'b010101, 'b010110, 'b011001, 'b011010,
    'b011100, 'b100011, 'b100101, 'b100110, 'b101001, 'b101010, 'b101100, 'b110001,
    'b110010, 'b110100, 'b000111, 'b001111, 'b010111, 'b011011, 'b011101, 'b011110,
    'b100111, 'b011111, 'b101111, 'b110111, 'b111011, 'b111101, 'b111110, 'b111111
  };

  typedef struct {
    logic [37:0] code;
    logic [31:0] data;
    logic        cor;
    logic        unc;
    logic [5:0]  syn;
    int          acc;
  } ent_t;

  ent_t q[$];

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int n_acc  = 0;
  int n_dlv  = 0;

  int          m_cor = 0;
  int          m_unc = 0;
  logic        m_cap_vld = 1'b0;
  logic [37:0] m_cap_code = '0;

  logic        got = 1'b0;
  logic [31:0] last_data;
  logic        last_cor;
  logic        last_unc;
  logic [5:0]  last_syn;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] m_chk(input logic [31:0] d);
    int unsigned c;
    c = 'b010101;
    for (int j = 0; j < 32; j++) if (d[j]) c = c ^ cols[j];
    return c[5:0];
  endfunction

  function automatic logic [37:0] enc(input logic [31:0] d);
    return {m_chk(d), d};
  endfunction

  function automatic ent_t model(input logic [37:0] code);
    ent_t e;
    e.code = code;
    e.syn  = code[37:32] ^ m_chk(code[31:0]);
    e.data = code[31:0];
    e.cor  = 1'b0;
    e.unc  = 1'b0;
    e.acc  = 0;
    if (e.syn == 6'd0) begin
      // clean
    end else if ($countones(e.syn) == 1) begin
      e.cor = 1'b1;
    end else begin
      e.unc = 1'b1;
      for (int j = 0; j < 32; j++) begin
        if (e.unc && cols[j] == int'(e.syn)) begin
          e.data = code[31:0] ^ (32'd1 << j);
          e.cor  = 1'b1;
          e.unc  = 1'b0;
        end
      end
    end
    return e;
  endfunction

  // One clock: check state at the falling edge, update model, pass the rising edge
  task automatic cycle();
    logic acc;
    logic dlv;
    logic exp_vld;
    logic exp_rdy;
    logic dc;
    logic du;
    ent_t e;
    @(negedge clk);
    exp_vld = (q.size() > 0) && (cyc >= q[0].acc + 2);
    exp_rdy = !((q.size() >= 2) && !bus.o_rdy);
    chk("o_vld", bus.o_vld, exp_vld);
    chk("i_rdy", bus.i_rdy, exp_rdy);
    chk("cor_cnt", cor_cnt, m_cor);
    chk("unc_cnt", unc_cnt, m_unc);
    chk("cap_vld", cap_vld, m_cap_vld);
    chk("cap_code", cap_code, m_cap_code);
    acc = bus.i_vld & bus.i_rdy;
    dlv = bus.o_vld & bus.o_rdy;
    dc  = 1'b0;
    du  = 1'b0;
    if (dlv) begin
      if (q.size() == 0) begin
        chk("spurious_dlv", 1, 0);
      end else begin
        e = q.pop_front();
        chk("o_data", bus.o_data, e.data);
        chk("o_cor", bus.o_cor, e.cor);
        chk("o_unc", bus.o_unc, e.unc);
        chk("o_syn", bus.o_syn, e.syn);
        last_data = bus.o_data;
        last_cor  = bus.o_cor;
        last_unc  = bus.o_unc;
        last_syn  = bus.o_syn;
        got = 1'b1;
        n_dlv++;
        dc = e.cor;
        du = e.unc;
      end
    end
    if (cnt_clr) begin
      m_cor      = dc ? 1 : 0;
      m_unc      = du ? 1 : 0;
      m_cap_vld  = du;
      m_cap_code = du ? e.code : '0;
    end else begin
      if (dc && m_cor != (1 << CNT_W) - 1) m_cor++;
      if (du && m_unc != (1 << CNT_W) - 1) m_unc++;
      if (du && !m_cap_vld) begin
        m_cap_vld  = 1'b1;
        m_cap_code = e.code;
      end
    end
    if (acc) begin
      e = model(bus.i_code);
      e.acc = cyc;
      q.push_back(e);
      n_acc++;
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic drain();
    bus.i_vld = 1'b0;
    bus.o_rdy = 1'b1;
    cnt_clr   = 1'b0;
    for (int k = 0; k < 12 && q.size() > 0; k++) cycle();
    chk("drain_empty", q.size(), 0);
  endtask

  task automatic send(input logic [37:0] code, input logic [31:0] xd,
                      input logic xc, input logic xu, input logic [5:0] xs);
    bus.i_vld  = 1'b1;
    bus.i_code = code;
    bus.o_rdy  = 1'b1;
    got        = 1'b0;
    cycle();
    bus.i_vld = 1'b0;
    for (int k = 0; k < 10 && !got; k++) cycle();
    chk("dir_timeout", got, 1);
    chk("dir_data", last_data, xd);
    chk("dir_cor", last_cor, xc);
    chk("dir_unc", last_unc, xu);
    chk("dir_syn", last_syn, xs);
  endtask

  function automatic logic [37:0] rand_code(input int nflip);
    logic [37:0] c;
    c = enc($urandom);
    for (int k = 0; k < nflip; k++) c = c ^ (38'd1 << $urandom_range(0, 37));
    return c;
  endfunction

  initial begin
    bus.i_vld  = 1'b0;
    bus.i_code = '0;
    bus.o_rdy  = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_o_vld", bus.o_vld, 0);
    chk("rst_i_rdy", bus.i_rdy, 1);
    chk("rst_o_data", bus.o_data, 0);
    chk("rst_cor_cnt", cor_cnt, 0);
    chk("rst_cap_vld", cap_vld, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed words
    send({6'b010101, 32'h0}, 32'h0, 1'b0, 1'b0, 6'b000000);
    send({6'b010101, 32'h1}, 32'h0, 1'b1, 1'b0, 6'b001011);
    chk("t2_cor_cnt", cor_cnt, 1);
    send({6'b110101, 32'h0}, 32'h0, 1'b1, 1'b0, 6'b100000);
    send({6'b101101, 32'h0}, 32'h0, 1'b0, 1'b1, 6'b111000);
    chk("t4_unc_cnt", unc_cnt, 1);
    chk("t4_cap_vld", cap_vld, 1);
    chk("t4_cap_code", cap_code, 38'h2D_0000_0000);
    $display("directed words done, compared %0d", n_cmp);

    // Randomized traffic with back-pressure and occasional clears
    for (int k = 0; k < 400; k++) begin
      bus.i_vld  = ($urandom_range(0, 3) != 0);
      bus.i_code = rand_code($urandom_range(0, 3));
      bus.o_rdy  = ($urandom_range(0, 3) != 0);
      cnt_clr    = ($urandom_range(0, 39) == 0);
      cycle();
    end
    drain();
    $display("random traffic done, accepted %0d delivered %0d", n_acc, n_dlv);

    // Back-to-back stream of 8 with a 3-cycle stall
    n_acc = 0;
    n_dlv = 0;
    for (int k = 1; k <= 30 && n_acc < 8; k++) begin
      bus.i_vld  = 1'b1;
      bus.i_code = rand_code($urandom_range(0, 1));
      bus.o_rdy  = !(k >= 3 && k <= 5);
      cycle();
    end
    drain();
    chk("stream_acc", n_acc, 8);
    chk("stream_dlv", n_dlv, 8);
    $display("stream done, accepted %0d delivered %0d", n_acc, n_dlv);

    // Saturation: clear, then 16 corrections
    cnt_clr   = 1'b1;
    bus.i_vld = 1'b0;
    cycle();
    cnt_clr = 1'b0;
    n_acc   = 0;
    for (int k = 0; k < 40 && n_acc < 16; k++) begin
      bus.i_vld  = 1'b1;
      bus.i_code = rand_code(0) ^ (38'd1 << $urandom_range(0, 37));
      bus.o_rdy  = 1'b1;
      cycle();
    end
    drain();
    chk("sat_cor_cnt", cor_cnt, 4'hF);

    // Clear coincident with a correction delivery
    bus.i_vld  = 1'b1;
    bus.i_code = {6'b010101, 32'h1};
    bus.o_rdy  = 1'b1;
    cycle();
    bus.i_vld = 1'b0;
    cycle();
    cnt_clr = 1'b1;
    cycle();
    cnt_clr = 1'b0;
    chk("clr_cor_cnt", cor_cnt, 1);
    $display("saturation and clear done, cor_cnt %0d", cor_cnt);

    // Reset in the middle of a stream
    for (int k = 0; k < 3; k++) begin
      bus.i_vld  = 1'b1;
      bus.i_code = rand_code(1);
      bus.o_rdy  = 1'b0;
      cycle();
    end
    rst_n = 1'b0;
    #1;
    chk("mid_rst_o_vld", bus.o_vld, 0);
    chk("mid_rst_cor_cnt", cor_cnt, 0);
    chk("mid_rst_unc_cnt", unc_cnt, 0);
    chk("mid_rst_cap_vld", cap_vld, 0);
    q.delete();
    m_cor      = 0;
    m_unc      = 0;
    m_cap_vld  = 1'b0;
    m_cap_code = '0;
    bus.i_vld  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    cyc++;
    #1;
    send({6'b010101, 32'h0}, 32'h0, 1'b0, 1'b0, 6'b000000);
    $display("mid-stream reset done");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
